// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port synchronous RAM.
package ram_pkg;

  // Controller phase: INIT sweeps the array to zero, RUN serves traffic.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_e;

  // Width of one byte-enable lane.
  localparam int BYTE_W = 8;

  // The read pipeline is only built for one or two stages of latency.
  function automatic bit rd_latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Response buffer for the RAM read port: a small synchronous FIFO with
// valid/ready on both sides. Storage resets to zero so the head word reads
// back as zero while the buffer is empty after reset.
module ram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] store;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [CW-1:0]               count;
  logic                        push;
  logic                        pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = store[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage, pointers and occupancy; push and pop may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= in_data;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dual_port_sync_ram.sv
// Dual-port synchronous RAM: one valid/ready write port with byte enables,
// one valid/ready read port with a RD_LATENCY-deep pipeline, in-order
// responses through a backpressurable buffer, and a zero sweep of the whole
// array after every reset.
// Optional feature macro: RAM_WR_BYPASS_EN -- a read and write hitting the
// same in-range address in the same cycle return the merged write data
// (write-first); without it the read sees the old contents.
module dual_port_sync_ram
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_rsp_valid,
  input  logic                    rd_rsp_ready,
  output logic [DATA_WIDTH-1:0]   rd_rsp_data,
  output logic                    rd_rsp_err,
  output logic                    init_done
);

  localparam int NB = DATA_WIDTH / BYTE_W;
  localparam int OW = $clog2(RD_LATENCY + 2);
  localparam logic [OW-1:0]         MAX_OUT   = OW'(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH:0]   LEN_W     = (ADDR_WIDTH + 1)'(LENGTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);

  if (!rd_latency_ok(RD_LATENCY) || (DATA_WIDTH % BYTE_W) != 0) begin : g_bad_cfg
    $error("dual_port_sync_ram: RD_LATENCY must be 1 or 2 and DATA_WIDTH a multiple of 8");
  end

  // ---------------------------------------------------------------- init FSM
  ram_state_e            state;
  ram_state_e            state_nxt;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  clr_en;

  // State and sweep pointer; any reset restarts the clear from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (clr_en) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // Next state and port enables: one word cleared per INIT cycle, then RUN forever.
  always_comb begin
    state_nxt = state;
    clr_en    = 1'b0;
    init_done = 1'b0;
    wr_ready  = 1'b0;
    unique case (state)
      INIT: begin
        clr_en = 1'b1;
        if (clr_ptr == LAST_ADDR) state_nxt = RUN;
      end
      RUN: begin
        init_done = 1'b1;
        wr_ready  = 1'b1;
      end
      default: state_nxt = INIT;
    endcase
  end

  // ------------------------------------------------------------ port decode
  logic                         wr_fire;
  logic                         wr_in_range;
  logic                         rd_fire;
  logic                         rd_in_range;
  logic [NB-1:0][BYTE_W-1:0]    wr_bytes;
  logic [NB-1:0][BYTE_W-1:0]    rd_word;

  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = ({1'b0, wr_addr} < LEN_W);
  assign rd_fire     = rd_req_valid & rd_req_ready;
  assign rd_in_range = ({1'b0, rd_addr} < LEN_W);
  assign wr_bytes    = wr_data;

`ifdef RAM_WR_BYPASS_EN
  logic wr_hit;
  assign wr_hit = wr_fire & wr_in_range & (wr_addr == rd_addr);
`endif

  // ------------------------------------------------------- byte-lane array
  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [BYTE_W-1:0] lane_mem [LENGTH];

    // One byte column: zero sweep during INIT, byte-enabled writes in RUN.
    // Out-of-range writes are accepted at the port and simply not stored.
    always_ff @(posedge clk) begin
      if (clr_en)                                   lane_mem[clr_ptr] <= '0;
      else if (wr_fire && wr_in_range && wr_be[b])  lane_mem[wr_addr] <= wr_bytes[b];
    end

`ifdef RAM_WR_BYPASS_EN
    assign rd_word[b] = (wr_hit && wr_be[b]) ? wr_bytes[b] : lane_mem[rd_addr];
`else
    assign rd_word[b] = lane_mem[rd_addr];
`endif
  end

  // ----------------------------------------------------------- read pipe
  // The array is sampled at the accepting edge; stage 0 is that sample.
  // Each further stage adds one cycle before the entry lands in the buffer.
  logic                  s0_vld;
  logic [DATA_WIDTH:0]   s0_rsp;
  logic                  push_vld;
  logic [DATA_WIDTH:0]   push_rsp;

  assign s0_vld = rd_fire;
  assign s0_rsp = rd_in_range ? {1'b0, rd_word} : {1'b1, {DATA_WIDTH{1'b0}}};

  if (RD_LATENCY == 1) begin : g_lat1
    assign push_vld = s0_vld;
    assign push_rsp = s0_rsp;
  end else begin : g_latn
    logic [RD_LATENCY-1:1]               vld_pipe;
    logic [RD_LATENCY-1:1][DATA_WIDTH:0] rsp_pipe;

    // Valid/data shift register; reset empties it so nothing lands after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        rsp_pipe <= '0;
      end else begin
        vld_pipe[1] <= s0_vld;
        rsp_pipe[1] <= s0_rsp;
        for (int s = 2; s < RD_LATENCY; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          rsp_pipe[s] <= rsp_pipe[s-1];
        end
      end
    end

    assign push_vld = vld_pipe[RD_LATENCY-1];
    assign push_rsp = rsp_pipe[RD_LATENCY-1];
  end

  // ----------------------------------------------------- response buffer
  logic fifo_in_ready;

  ram_rsp_fifo #(
    .DEPTH (RD_LATENCY + 1),
    .WIDTH (DATA_WIDTH + 1)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push_vld),
    .in_ready  (fifo_in_ready),
    .in_data   (push_rsp),
    .out_valid (rd_rsp_valid),
    .out_ready (rd_rsp_ready),
    .out_data  ({rd_rsp_err, rd_rsp_data})
  );

  // The outstanding limit below guarantees every landing entry finds room.
  always_ff @(posedge clk) begin
    if (rst_n && push_vld) begin
      assert (fifo_in_ready) else $error("dual_port_sync_ram: response buffer overflow");
    end
  end

  // ------------------------------------------------------ flow control
  logic [OW-1:0] outstanding;
  logic          rsp_pop;

  assign rsp_pop      = rd_rsp_valid & rd_rsp_ready;
  assign rd_req_ready = init_done & (outstanding < MAX_OUT);

  // Reads accepted but not yet consumed, in flight or buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      unique case ({rd_fire, rsp_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// Self-checking bench for dual_port_sync_ram (LENGTH=12, RD_LATENCY=2).
module tb_dual_port_sync_ram;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int NB  = DW / 8;
  localparam int LEN = 12;
  localparam int RDL = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_rsp_valid;
  logic          rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;
  logic          rd_rsp_err;
  logic          init_done;

  dual_port_sync_ram #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LENGTH     (LEN),
    .RD_LATENCY (RDL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_err   (rd_rsp_err),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            id;
  } exp_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NB-1:0] be;
    logic [DW-1:0] exp;
    logic          err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every consumed response is compared against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rd_rsp_valid && rd_rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=%h expected=none", rd_rsp_data);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("rsp%0d_data", e.id), rd_rsp_data, e.data);
        check($sformatf("rsp%0d_err", e.id), {31'b0, rd_rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    bit ok;
    ok = 1'b0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); ok = wr_ready;
      @(posedge clk);
    end
    #1 wr_valid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL wr_timeout addr=%0d", a); end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e, input int id);
    bit ok;
    ok = 1'b0;
    rd_req_valid = 1'b1; rd_addr = a;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); ok = rd_req_ready;
      if (ok) sb_q.push_back('{d, e, id});
      @(posedge clk);
    end
    #1 rd_req_valid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL rd_timeout addr=%0d", a); end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(posedge clk);
    #1 check(name, sb_q.size(), 0);
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done && n < 50) begin @(posedge clk); n++; #1; end
    check(name, n, LEN);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [AW-1:0] bp_addr [3];
    logic [DW-1:0] bp_exp  [3];
    logic [DW-1:0] tp_exp  [6];
    logic [DW-1:0] sc_exp;
    logic [DW-1:0] held;
    int acc;
    int lat;

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_req_valid = 1'b0; rd_addr = '0; rd_rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_req_ready", rd_req_ready, 0);
    check("rst_rsp_valid", rd_rsp_valid, 0);
    check("rst_rsp_data", rd_rsp_data, 0);
    check("rst_rsp_err", rd_rsp_err, 0);
    check("rst_init_done", init_done, 0);

    // Clear sweep takes LENGTH cycles after release
    rst_n = 1'b1;
    wait_init("init_cycles");
    check("run_wr_ready", wr_ready, 1);
    check("run_rd_req_ready", rd_req_ready, 1);

    // Vector table: cleared array, byte enables, range boundary, dropped writes
    for (int a = 0; a < LEN; a++) vt.push_back('{0, AW'(a), 32'h0, 4'h0, 32'h0, 1'b0});
    vt.push_back('{1, 4'd5,  32'hAABBCCDD, 4'b0101, 32'h0, 1'b0});
    vt.push_back('{0, 4'd5,  32'h0,        4'h0,    32'h00BB00DD, 1'b0});
    vt.push_back('{1, 4'd5,  32'h11223344, 4'b1010, 32'h0, 1'b0});
    vt.push_back('{0, 4'd5,  32'h0,        4'h0,    32'h11BB33DD, 1'b0});
    vt.push_back('{1, 4'd5,  32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0});
    vt.push_back('{0, 4'd5,  32'h0,        4'h0,    32'h11BB33DD, 1'b0});
    vt.push_back('{1, 4'd13, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0});
    vt.push_back('{0, 4'd1,  32'h0,        4'h0,    32'h0, 1'b0});
    vt.push_back('{0, 4'd13, 32'h0,        4'h0,    32'h0, 1'b1});
    vt.push_back('{0, 4'd15, 32'h0,        4'h0,    32'h0, 1'b1});
    vt.push_back('{0, 4'd12, 32'h0,        4'h0,    32'h0, 1'b1});
    vt.push_back('{0, 4'd11, 32'h0,        4'h0,    32'h0, 1'b0});
    vt.push_back('{1, 4'd11, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0});
    vt.push_back('{0, 4'd11, 32'h0,        4'h0,    32'hCAFEF00D, 1'b0});
    vt.push_back('{1, 4'd0,  32'h01020304, 4'b1111, 32'h0, 1'b0});
    vt.push_back('{0, 4'd0,  32'h0,        4'h0,    32'h01020304, 1'b0});
    vt.push_back('{1, 4'd3,  32'h00000055, 4'b1111, 32'h0, 1'b0});
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].data, vt[i].be);
      else          rd(vt[i].addr, vt[i].exp, vt[i].err, i);
    end
    drain("drain_table");

    // Accept-to-data latency
    rd(4'd5, 32'h11BB33DD, 1'b0, 100);
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); lat++;
      if (rd_rsp_valid) break;
    end
    check("rd_latency", lat, RDL);
    drain("drain_latency");

    // Backpressure: only RD_LATENCY+1 reads accepted, response held stable
    bp_addr = '{4'd5, 4'd11, 4'd0};
    bp_exp  = '{32'h11BB33DD, 32'hCAFEF00D, 32'h01020304};
    @(posedge clk); #1;
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1; rd_addr = bp_addr[0];
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rd_req_ready) begin
        if (acc < 3) sb_q.push_back('{bp_exp[acc], 1'b0, 200 + acc});
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 3) rd_addr = bp_addr[acc];
    end
    rd_req_valid = 1'b0;
    check("bp_accepts", acc, RDL + 1);
    check("bp_req_ready", rd_req_ready, 0);
    check("bp_rsp_valid", rd_rsp_valid, 1);
    held = rd_rsp_data;
    repeat (2) @(posedge clk);
    #1 check("bp_hold", rd_rsp_data, held);
    check("bp_head", rd_rsp_data, bp_exp[0]);
    rd_rsp_ready = 1'b1;
    drain("drain_bp");

    // Same-cycle read and write to addr 3 (old 0x55)
`ifdef RAM_WR_BYPASS_EN
    sc_exp = 32'h00001234;
`else
    sc_exp = 32'h00000055;
`endif
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'h00001234; wr_be = 4'hF;
    rd_req_valid = 1'b1; rd_addr = 4'd3;
    @(negedge clk);
    check("sc_ready", {30'b0, wr_ready, rd_req_ready}, 32'h3);
    sb_q.push_back('{sc_exp, 1'b0, 300});
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    rd(4'd3, 32'h00001234, 1'b0, 301);

    // Write in the cycle after a read of the same address: read sees old data
    @(posedge clk); #1;
    rd_req_valid = 1'b1; rd_addr = 4'd3;
    @(negedge clk);
    if (rd_req_ready) sb_q.push_back('{32'h00001234, 1'b0, 302});
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000BEEF; wr_be = 4'hF;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rd(4'd3, 32'h0000BEEF, 1'b0, 303);
    drain("drain_sc");

    // Full throughput: one read accepted per cycle
    tp_exp = '{32'h01020304, 32'h0, 32'h0, 32'h0000BEEF, 32'h0, 32'h11BB33DD};
    rd_req_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      rd_addr = AW'(i);
      @(negedge clk);
      if (rd_req_ready) begin
        sb_q.push_back('{tp_exp[i], 1'b0, 400 + i});
        acc++;
      end
      @(posedge clk); #1;
    end
    rd_req_valid = 1'b0;
    check("tp_accepts", acc, 6);
    drain("drain_tp");

    // Reset with two responses pending, then re-init clears the array
    rd_rsp_ready = 1'b0;
    rd(4'd5, 32'h11BB33DD, 1'b0, 500);
    rd(4'd11, 32'hCAFEF00D, 1'b0, 501);
    repeat (3) @(posedge clk);
    #1 check("pre_rst_rsp_valid", rd_rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rd_rsp_valid, 0);
    check("mid_rst_rsp_data", rd_rsp_data, 0);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_rd_req_ready", rd_req_ready, 0);
    sb_q.delete();
    rd_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init("reinit_cycles");
    rd(4'd0,  32'h0, 1'b0, 600);
    rd(4'd3,  32'h0, 1'b0, 601);
    rd(4'd5,  32'h0, 1'b0, 602);
    rd(4'd11, 32'h0, 1'b0, 603);
    drain("drain_reinit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
